// File: rtl/lsu_pkg.sv
// Shared types, constants and helpers for the load/store control stage.
// The MMIO window constants must match the physical-memory model's device map.
package lsu_pkg;

   localparam int DATA_W = 64;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam logic [63:0] PMEM_BASE = 64'h0000_0000_8000_0000;
   localparam logic [63:0] MMIO_BASE = 64'h0000_0000_A000_0000;
   localparam logic [63:0] MMIO_END  = 64'h0000_0000_B000_0000;

   function automatic logic [7:0] base_mask(input size_e sz);
      logic [7:0] m;
      unique case (sz)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   // Natural alignment: the low address bits covered by the access size must be zero.
   function automatic logic is_misaligned(input size_e sz, input logic [2:0] off);
      logic [2:0] low;
      unique case (sz)
         SZ_B:    low = 3'b000;
         SZ_H:    low = 3'b001;
         SZ_W:    low = 3'b011;
         default: low = 3'b111;
      endcase
      return (off & low) != 3'b000;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake and physical-memory port of the load/store stage.
// slave = lsu_ctrl side, master = MEM stage plus memory model side.
interface lsu_if;
   import lsu_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [1:0]        req_size;
   logic              req_signed;

   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_mmio;
   logic              resp_err;

   logic [DATA_W-1:0] pmem_raddr;
   logic              pmem_rvalid;
   logic [DATA_W-1:0] pmem_rdata;
   logic [DATA_W-1:0] pmem_waddr;
   logic [DATA_W-1:0] pmem_wdata;
   logic [7:0]        pmem_mask;
   logic              pmem_visit;

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_size, req_signed,
      output req_ready,
      output resp_valid, resp_rdata, resp_mmio, resp_err,
      input  resp_ready,
      output pmem_raddr, pmem_rvalid, pmem_waddr, pmem_wdata, pmem_mask,
      input  pmem_rdata, pmem_visit
   );

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_size, req_signed,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_mmio, resp_err,
      output resp_ready,
      input  pmem_raddr, pmem_rvalid, pmem_waddr, pmem_wdata, pmem_mask,
      output pmem_rdata, pmem_visit
   );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store data/mask shifted into the 8-byte word, load data
// shifted down, truncated to size and sign/zero-extended.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]        addr_lo,
   input  size_e             size,
   input  logic              sign,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] wdata_sh,
   output logic [7:0]        mask_sh,
   output logic [DATA_W-1:0] rdata_ext
);

   logic [5:0]        bit_sh;
   logic [DATA_W-1:0] rdata_sh;

   assign bit_sh = {addr_lo, 3'b000};

   // Lanes pushed past byte 7 fall off the top of both data and mask.
   assign wdata_sh = wdata << bit_sh;
   assign mask_sh  = base_mask(size) << addr_lo;
   assign rdata_sh = rdata >> bit_sh;

   always_comb begin
      rdata_ext = rdata_sh;
      unique case (size)
         SZ_B:    rdata_ext = sign ? {{56{rdata_sh[7]}},  rdata_sh[7:0]}
                                   : {56'h0, rdata_sh[7:0]};
         SZ_H:    rdata_ext = sign ? {{48{rdata_sh[15]}}, rdata_sh[15:0]}
                                   : {48'h0, rdata_sh[15:0]};
         SZ_W:    rdata_ext = sign ? {{32{rdata_sh[31]}}, rdata_sh[31:0]}
                                   : {32'h0, rdata_sh[31:0]};
         default: rdata_ext = rdata_sh;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the physical-memory model: one request per
// handshake, single-cycle memory strobe, emulated latency. Optional: LSU_MISALIGN_CHK_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | req_ready high, waiting for a request
// ST_ACCESS | one-cycle pmem strobe; read data and visit flag latched at exit
// ST_WAIT   | latency down-counter running, leaves at terminal count 0
// ST_RESP   | resp_valid high with stable payload until resp_ready
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int LATENCY = 0,
   parameter int XLEN    = 64
) (
   input  logic  clock,
   input  logic  reset,
   lsu_if.slave  bus
);

   localparam bit       HAS_WAIT    = (LATENCY > 0);
   localparam int       WAIT_INIT_I = (LATENCY > 0) ? LATENCY - 1 : 0;
   localparam logic [3:0] WAIT_INIT = WAIT_INIT_I[3:0];

   state_e            state_q, state_d;
   logic              wen_q, sign_q, visit_q, err_q;
   logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
   size_e             size_q;
   logic [3:0]        cnt_q;
   logic              misalign;

   logic [XLEN-1:0]   wdata_sh, rdata_ext;
   logic [7:0]        mask_sh;

`ifdef LSU_MISALIGN_CHK_EN
   assign misalign = is_misaligned(size_e'(bus.req_size), bus.req_addr[2:0]);
`else
   assign misalign = 1'b0;
`endif

   lsu_align u_align (
      .addr_lo   (addr_q[2:0]),
      .size      (size_q),
      .sign      (sign_q),
      .wdata     (wdata_q),
      .rdata     (rdata_q),
      .wdata_sh  (wdata_sh),
      .mask_sh   (mask_sh),
      .rdata_ext (rdata_ext)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         wen_q   <= 1'b0;
         sign_q  <= 1'b0;
         visit_q <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         size_q  <= SZ_B;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  wen_q   <= bus.req_wen;
                  sign_q  <= bus.req_signed;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  size_q  <= size_e'(bus.req_size);
                  rdata_q <= '0;
                  visit_q <= 1'b0;
                  err_q   <= misalign;
               end
            end
            ST_ACCESS: begin
               rdata_q <= bus.pmem_rdata;
               visit_q <= bus.pmem_visit;
               cnt_q   <= WAIT_INIT;
            end
            ST_WAIT: begin
               if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d         = state_q;
      bus.req_ready   = 1'b0;
      bus.resp_valid  = 1'b0;
      bus.pmem_rvalid = 1'b0;
      bus.pmem_mask   = 8'h00;
      unique case (state_q)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_d = misalign ? ST_RESP : ST_ACCESS;
         end
         ST_ACCESS: begin
            // The memory model writes combinationally: mask lives for this cycle only.
            bus.pmem_rvalid = ~wen_q;
            bus.pmem_mask   = wen_q ? mask_sh : 8'h00;
            state_d         = HAS_WAIT ? ST_WAIT : ST_RESP;
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
         end
         ST_RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.pmem_raddr = {addr_q[XLEN-1:3], 3'b000};
   assign bus.pmem_waddr = {addr_q[XLEN-1:3], 3'b000};
   assign bus.pmem_wdata = wdata_sh;

   assign bus.resp_rdata = (state_q == ST_RESP && !wen_q && !err_q) ? rdata_ext : '0;
   assign bus.resp_mmio  = (state_q == ST_RESP) & visit_q;

`ifdef LSU_MISALIGN_CHK_EN
   assign bus.resp_err = (state_q == ST_RESP) & err_q;
`else
   assign bus.resp_err = 1'b0;
`endif

endmodule
